// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side packer.
// Lane-counter sizing and keep-mask helper.
package fifo_pkg;

    localparam int RATIO_DEF = 4;
    localparam int CNT_W     = $clog2(RATIO_DEF);

    function automatic int cnt_width(input int ratio);
        return (ratio > 2) ? $clog2(ratio) : 1;
    endfunction

    function automatic logic [31:0] mask_low(input int n);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_pack_idle_timer.sv
// Idle counter for the packer: raises flush after TIMEOUT idle cycles
// with a partial word pending and the output slot free.
module fifo_pack_idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic pop,
    input  logic cnt_zero,
    input  logic out_free,
    output logic flush
);

    localparam int              IW   = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0]   TMAX = IW'(TIMEOUT);

    logic [IW-1:0] idle;

    // A pop in the same cycle always wins over a flush.
    assign flush = (idle == TMAX) & ~cnt_zero & out_free & ~pop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            idle <= '0;
        end else if (pop | cnt_zero | flush) begin
            idle <= '0;
        end else if (idle != TMAX) begin
            idle <= idle + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_read_packer.sv
// Packs RATIO show-ahead FIFO words into one wide valid/ready word.
// FIFO_PACK_TIMEOUT_EN enables flushing of idle partial words.
module fifo_read_packer
    import fifo_pkg::*;
#(
    parameter int BITS    = 8,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  FIFO_EMPTY,
    input  logic [BITS-1:0]       FIFO_Q,
    output logic                  FIFO_RE,
    output logic [RATIO*BITS-1:0] OUT_DATA,
    output logic [RATIO-1:0]      OUT_KEEP,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY
);

    localparam int            CW   = cnt_width(RATIO);
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    logic [CW-1:0]         cnt;
    logic [BITS-1:0]       lanes [RATIO-1];
    logic                  out_free;
    logic                  last;
    logic                  pop;
    logic [RATIO*BITS-1:0] full_word;

    assign out_free = ~OUT_VALID | OUT_READY;
    assign last     = (cnt == LAST);
    assign FIFO_RE  = RESET & ~FIFO_EMPTY & (~last | out_free);
    assign pop      = FIFO_RE & ~FIFO_EMPTY;

    // Last lane comes straight from the FIFO head on the completing pop.
    always_comb begin
        full_word = '0;
        for (int i = 0; i < RATIO - 1; i++) begin
            full_word[i*BITS +: BITS] = lanes[i];
        end
        full_word[(RATIO-1)*BITS +: BITS] = FIFO_Q;
    end

`ifdef FIFO_PACK_TIMEOUT_EN
    logic                  flush;
    logic [RATIO*BITS-1:0] part_word;

    fifo_pack_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle (
        .clk      (CLK),
        .reset    (RESET),
        .pop      (pop),
        .cnt_zero (cnt == '0),
        .out_free (out_free),
        .flush    (flush)
    );

    always_comb begin
        part_word = '0;
        for (int i = 0; i < RATIO - 1; i++) begin
            if (CW'(i) < cnt) part_word[i*BITS +: BITS] = lanes[i];
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cnt       <= '0;
            OUT_DATA  <= '0;
            OUT_KEEP  <= '0;
            OUT_VALID <= 1'b0;
            for (int i = 0; i < RATIO - 1; i++) lanes[i] <= '0;
        end else begin
            if (OUT_VALID && OUT_READY) OUT_VALID <= 1'b0;
            if (pop) begin
                if (last) begin
                    OUT_DATA  <= full_word;
                    OUT_KEEP  <= '1;
                    OUT_VALID <= 1'b1;
                    cnt       <= '0;
                end else begin
                    for (int i = 0; i < RATIO - 1; i++) begin
                        if (cnt == CW'(i)) lanes[i] <= FIFO_Q;
                    end
                    cnt <= cnt + 1'b1;
                end
            end
`ifdef FIFO_PACK_TIMEOUT_EN
            else if (flush) begin
                OUT_DATA  <= part_word;
                OUT_KEEP  <= RATIO'(mask_low(int'(cnt)));
                OUT_VALID <= 1'b1;
                cnt       <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fifo_read_packer.sv
// Scoreboard bench for fifo_read_packer: FIFO model, directed
// stimulus pushing expected words, monitor popping on accept.
module tb_fifo_read_packer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        FIFO_EMPTY = 1'b1;
    logic [7:0]  FIFO_Q = 8'h00;
    logic        FIFO_RE;
    logic [31:0] OUT_DATA;
    logic [3:0]  OUT_KEEP;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  fq[$];
    logic [35:0] expq[$];
    int          acc_cyc[$];
    logic        will_pop = 1'b0;
    logic        stall_prev = 1'b0;
    logic [35:0] held = '0;

    fifo_read_packer #(
        .BITS    (8),
        .RATIO   (4),
        .TIMEOUT (16)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_Q     (FIFO_Q),
        .FIFO_RE    (FIFO_RE),
        .OUT_DATA   (OUT_DATA),
        .OUT_KEEP   (OUT_KEEP),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string n, input logic [35:0] a,
                       input logic [35:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", n, a, e);
        end
    endtask

    // Show-ahead FIFO model: head refreshed mid-low-phase.
    always @(negedge CLK) begin
        #2;
        FIFO_EMPTY = (fq.size() == 0);
        FIFO_Q = (fq.size() != 0) ? fq[0] : 8'h00;
        #1;
        will_pop = FIFO_RE && !FIFO_EMPTY;
    end

    always @(posedge CLK) begin
        cyc++;
        if (will_pop) begin
            void'(fq.pop_front());
            will_pop = 1'b0;
        end
    end

    // Monitor: compare every accepted word, check hold while stalled.
    always @(negedge CLK) begin
        #3;
        if (stall_prev && RESET)
            chk("hold", {OUT_DATA, OUT_KEEP}, held);
        if (RESET && OUT_VALID && OUT_READY) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected got %h want none",
                         {OUT_DATA, OUT_KEEP});
            end else begin
                chk("word", {OUT_DATA, OUT_KEEP}, expq.pop_front());
            end
            acc_cyc.push_back(cyc);
        end
        stall_prev = RESET && OUT_VALID && !OUT_READY;
        held = {OUT_DATA, OUT_KEEP};
    end

    task automatic sample();
        @(negedge CLK);
        #4;
    endtask

    task automatic wait_fifo(input int lim);
        int n = 0;
        while (fq.size() != 0 && n < lim) begin
            sample();
            n++;
        end
        chk("fifo_drain", 36'(fq.size() == 0), 36'd1);
    endtask

    task automatic wait_exp(input int lim);
        int n = 0;
        while (expq.size() != 0 && n < lim) begin
            sample();
            n++;
        end
        chk("exp_drain", 36'(expq.size()), 36'd0);
    endtask

    task automatic push_words(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) fq.push_back(b + 8'(i));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        // Reset held with a non-empty FIFO
        fq.push_back(8'h11);
        fq.push_back(8'h22);
        fq.push_back(8'h33);
        fq.push_back(8'h44);
        expq.push_back({32'h44332211, 4'hF});
        repeat (3) sample();
        chk("rst_re", 36'(FIFO_RE), 36'd0);
        chk("rst_valid", 36'(OUT_VALID), 36'd0);
        chk("rst_keep", 36'(OUT_KEEP), 36'd0);
        chk("rst_data", 36'(OUT_DATA), 36'd0);
        @(negedge CLK);
        RESET = 1'b1;
        #4;
        chk("release_re", 36'(FIFO_RE), 36'd1);
        wait_fifo(20);
        chk("latency", 36'(OUT_VALID), 36'd1);
        wait_exp(10);

        // Back-pressure with 8 words queued
        @(negedge CLK);
        OUT_READY = 1'b0;
        push_words(8'h01, 8);
        expq.push_back({32'h04030201, 4'hF});
        expq.push_back({32'h08070605, 4'hF});
        for (int n = 0; n < 30 && fq.size() != 1; n++) sample();
        repeat (3) sample();
        chk("bp_re", 36'(FIFO_RE), 36'd0);
        chk("bp_left", 36'(fq.size()), 36'd1);
        chk("bp_valid", 36'(OUT_VALID), 36'd1);
        @(negedge CLK);
        OUT_READY = 1'b1;
        wait_exp(20);

        // Back-to-back, 16 words
        @(negedge CLK);
        acc_cyc.delete();
        push_words(8'h10, 16);
        expq.push_back({32'h13121110, 4'hF});
        expq.push_back({32'h17161514, 4'hF});
        expq.push_back({32'h1B1A1918, 4'hF});
        expq.push_back({32'h1F1E1D1C, 4'hF});
        wait_exp(40);
        chk("b2b_cnt", 36'(acc_cyc.size()), 36'd4);
        for (int k = 1; k < 4; k++) begin
            chk("b2b_gap",
                36'((acc_cyc.size() > k) ?
                    acc_cyc[k] - acc_cyc[k-1] : -1),
                36'd4);
        end

        // Mid-fill reset
        @(negedge CLK);
        push_words(8'hA1, 2);
        wait_fifo(10);
        @(negedge CLK);
        RESET = 1'b0;
        #4;
        chk("mid_rst_valid", 36'(OUT_VALID), 36'd0);
        @(negedge CLK);
        RESET = 1'b1;
        push_words(8'hB1, 4);
        expq.push_back({32'hB4B3B2B1, 4'hF});
        wait_exp(20);

        // Partial word left idle
        @(negedge CLK);
        push_words(8'hC1, 2);
`ifdef FIFO_PACK_TIMEOUT_EN
        expq.push_back({32'h0000C2C1, 4'h3});
        wait_exp(40);
`else
        repeat (30) sample();
        chk("no_flush", 36'(OUT_VALID), 36'd0);
        @(negedge CLK);
        push_words(8'hC3, 2);
        expq.push_back({32'hC4C3C2C1, 4'hF});
        wait_exp(20);
`endif

        repeat (5) sample();
        chk("final_exp", 36'(expq.size()), 36'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
